// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war playfield.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WIN  = 2'd1,
        DONE = 2'd2
    } tug_state_t;

    function automatic int center_index(input int num_lights);
        return (num_lights - 1) / 2;
    endfunction

endpackage

// File: rtl/press_edge.sv
// Rising-edge detector for a synchronised button level. The previous sample
// resets to 1 so a button held through Reset is not seen as a press.
module press_edge (
    input  logic Clock,
    input  logic Reset,
    input  logic level,
    output logic rise
);

    logic prev_r;

    // Track the previous level of the button every cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= level;
        end
    end

    assign rise = level & ~prev_r;

endmodule

// File: rtl/tug_playfield.sv
// Tug-of-war light row: marker position, round wins, per-player scores and
// match end, with every output held in a register.
module tug_playfield
    import tug_pkg::*;
#(
    parameter int NUM_LIGHTS = 9,
    parameter int WIN_ROUNDS = 7,
    parameter int SCORE_W    = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  L,
    input  logic                  R,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [1:0]            round_win,
    output logic [SCORE_W-1:0]    left_score,
    output logic [SCORE_W-1:0]    right_score,
    output logic                  match_over
);

    localparam int POS_W = $clog2(NUM_LIGHTS);
    localparam logic [POS_W-1:0]   POS_C   = POS_W'(center_index(NUM_LIGHTS));
    localparam logic [POS_W-1:0]   POS_MAX = POS_W'(NUM_LIGHTS - 1);
    localparam logic [SCORE_W-1:0] SCORE_END = SCORE_W'(WIN_ROUNDS);

    if ((NUM_LIGHTS < 3) || ((NUM_LIGHTS % 2) == 0) ||
        (WIN_ROUNDS < 1) || (WIN_ROUNDS > ((1 << SCORE_W) - 1))) begin : g_param_check
        $error("tug_playfield: illegal NUM_LIGHTS / WIN_ROUNDS / SCORE_W combination");
    end

    function automatic logic [NUM_LIGHTS-1:0] one_hot(input logic [POS_W-1:0] idx);
        logic [NUM_LIGHTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic l_rise_s;
    logic r_rise_s;

    press_edge u_edge_l (.Clock(Clock), .Reset(Reset), .level(L), .rise(l_rise_s));
    press_edge u_edge_r (.Clock(Clock), .Reset(Reset), .level(R), .rise(r_rise_s));

    tug_state_t            state_r,       state_s;
    logic [POS_W-1:0]      pos_r,         pos_s;
    logic                  winner_left_r, winner_left_s;
    logic [SCORE_W-1:0]    left_score_r,  left_score_s;
    logic [SCORE_W-1:0]    right_score_r, right_score_s;
    logic [NUM_LIGHTS-1:0] lights_r,      lights_s;
    logic [1:0]            round_win_r,   round_win_s;
    logic                  match_over_r,  match_over_s;
    logic                  left_only_s;
    logic                  right_only_s;

    // Next state and next registered outputs
    always_comb begin
        state_s       = state_r;
        pos_s         = pos_r;
        winner_left_s = winner_left_r;
        left_score_s  = left_score_r;
        right_score_s = right_score_r;
        lights_s      = lights_r;
        round_win_s   = 2'b00;
        match_over_s  = match_over_r;
        left_only_s   = l_rise_s & ~r_rise_s;
        right_only_s  = r_rise_s & ~l_rise_s;

        case (state_r)
            PLAY: begin
                if (left_only_s) begin
                    if (pos_r == POS_MAX) begin
                        state_s       = WIN;
                        winner_left_s = 1'b1;
                        left_score_s  = left_score_r + SCORE_W'(1);
                        round_win_s   = 2'b10;
                        lights_s      = '0;
                    end else begin
                        pos_s    = pos_r + POS_W'(1);
                        lights_s = one_hot(pos_r + POS_W'(1));
                    end
                end else if (right_only_s) begin
                    if (pos_r == {POS_W{1'b0}}) begin
                        state_s       = WIN;
                        winner_left_s = 1'b0;
                        right_score_s = right_score_r + SCORE_W'(1);
                        round_win_s   = 2'b01;
                        lights_s      = '0;
                    end else begin
                        pos_s    = pos_r - POS_W'(1);
                        lights_s = one_hot(pos_r - POS_W'(1));
                    end
                end else begin
                    lights_s = one_hot(pos_r);
                end
            end
            WIN: begin
                // Scores were bumped on entry to WIN, so compare the held value
                if ((winner_left_r ? left_score_r : right_score_r) == SCORE_END) begin
                    state_s      = DONE;
                    match_over_s = 1'b1;
                    lights_s     = winner_left_r ? one_hot(POS_MAX) : one_hot({POS_W{1'b0}});
                end else begin
                    state_s  = PLAY;
                    pos_s    = POS_C;
                    lights_s = one_hot(POS_C);
                end
            end
            DONE: begin
                match_over_s = 1'b1;
                lights_s     = winner_left_r ? one_hot(POS_MAX) : one_hot({POS_W{1'b0}});
            end
            default: begin
                state_s      = PLAY;
                pos_s        = POS_C;
                lights_s     = one_hot(POS_C);
                match_over_s = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r       <= PLAY;
            pos_r         <= POS_C;
            winner_left_r <= 1'b0;
            left_score_r  <= '0;
            right_score_r <= '0;
            lights_r      <= one_hot(POS_C);
            round_win_r   <= 2'b00;
            match_over_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            pos_r         <= pos_s;
            winner_left_r <= winner_left_s;
            left_score_r  <= left_score_s;
            right_score_r <= right_score_s;
            lights_r      <= lights_s;
            round_win_r   <= round_win_s;
            match_over_r  <= match_over_s;
        end
    end

    assign lights      = lights_r;
    assign round_win   = round_win_r;
    assign left_score  = left_score_r;
    assign right_score = right_score_r;
    assign match_over  = match_over_r;

endmodule

// File: doc/tug_playfield.md
# tug_playfield

Parametrised tug-of-war playfield. It replaces the per-LED light cells with one block that owns the whole row: marker position, press edge detection, round wins, per-player scores and match end. It sits between the synchronised player buttons and the LED/HEX drivers at the top level of the tug-of-war game.

## Interface
Parameters:
- NUM_LIGHTS, default 9: number of lights in the row. Must be odd and at least 3.
- WIN_ROUNDS, default 7: round wins needed to take the match. Range 1 to 2^SCORE_W-1.
- SCORE_W, default 3: width of each score counter.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- L  in  1  left player button level, already synchronised to Clock.
- R  in  1  right player button level, already synchronised to Clock.
- lights  out  NUM_LIGHTS  light row. Bit NUM_LIGHTS-1 is the leftmost light; bit 0 is the rightmost.
- round_win  out  2  {left, right}. One-cycle pulse when a round is won.
- left_score  out  SCORE_W  left player round wins.
- right_score  out  SCORE_W  right player round wins.
- match_over  out  1  high once either score reaches WIN_ROUNDS.

## Operation
- Press detection:
  - A press is a rising edge: the level is 1 this cycle and the registered previous sample is 0.
  - Previous-sample registers reset to 1, so a button held through Reset does not count as a press.
- Marker position:
  - pos is an index from 0 to NUM_LIGHTS-1. Centre is C = (NUM_LIGHTS-1)/2.
  - A left-only press sets pos+1. A right-only press sets pos-1.
  - Left and right presses in the same cycle leave pos unchanged, with no win.
- State machine (states PLAY, WIN, DONE):
  - PLAY: lights is one-hot at pos.
  - PLAY, left-only press with pos == NUM_LIGHTS-1: go to WIN and increment left_score. Right-only press with pos == 0: go to WIN and increment right_score. These are the only win conditions.
  - WIN lasts one cycle: lights = 0, and the round_win bit for the winning side = 1.
    - If the new score equals WIN_ROUNDS, next state is DONE.
    - Otherwise next state is PLAY with pos = C.
  - DONE: match_over = 1 and lights is one-hot at the winner's edge light (left winner: bit NUM_LIGHTS-1; right winner: bit 0). All presses are ignored. Only Reset exits DONE.
- In WIN and DONE, presses are discarded, but the previous-sample registers keep tracking their inputs.
- Scores never exceed WIN_ROUNDS, so there is no wrap.
- Reset values:
  - state PLAY, pos = C, lights = one-hot at C.
  - left_score = 0, right_score = 0.
  - round_win = 0, match_over = 0.
  - Reset mid-round, in WIN or in DONE takes effect at the same clock edge.

## Timing
- An input rise seen at posedge k moves lights at posedge k. Latency is 1 cycle from the input change.
- A winning press sampled at edge k gives WIN outputs after edge k: the round_win pulse, the score increment and dark lights.
- After edge k+1 the block shows either PLAY with the centre light, or DONE.
- A held button produces exactly one press. The player must release (level 0 for at least 1 cycle) before the next press counts.
- All outputs are registered. No combinational path runs from L or R to any output.

## Structure
- Package tug_pkg holds:
  - the state enum (PLAY, WIN, DONE);
  - a function for the centre index of a given NUM_LIGHTS.
- Sub-module press_edge: rising-edge detector with its previous-sample register reset to 1. Instantiated once for L and once for R.
- Parameter legality (NUM_LIGHTS odd and at least 3; WIN_ROUNDS within SCORE_W) is checked at elaboration.

## Test plan
All scenarios use the defaults (NUM_LIGHTS=9, WIN_ROUNDS=7, SCORE_W=3).
- Reset 2 cycles -> lights = 9'b000010000, both scores 0, round_win = 0, match_over = 0.
- L held high for 6 cycles from centre -> lights = 9'b000100000 after the first edge and unchanged afterwards. Release, then rise again -> 9'b001000000.
- L and R rising in the same cycle at centre -> lights stay 9'b000010000, no round_win.
- 5 separate L presses from centre:
  - after the 4th press -> lights = 9'b100000000;
  - the 5th press -> round_win = 2'b10 for exactly 1 cycle, left_score = 1, lights = 0;
  - next cycle -> lights = 9'b000010000.
- Left wins 7 rounds -> match_over = 1 and lights = 9'b100000000 held. Further L and R presses change nothing. Reset restores the reset values.
- Three R presses, then Reset with L held high through Reset -> lights = centre after Reset. No move while L stays high; a later L release and rise moves lights to 9'b000100000.
